ahb_mem_slave: RTL and testbench

- AHB-Lite responder: the slave end of the bus that the bridge-side master drives.
- Decodes a fixed address window and backs it with a word-organised register memory.
- Inserts a configurable number of wait states and returns OKAY or the two-cycle ERROR response.
- Serves as the bus-side target for bridge and bus-master bring-up.

---
 rtl/ahb_mem_slave.sv | 80 ++++++++
 tb/tb_ahb_mem_slave.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite responder backed by a word memory, with fixed wait states and two-cycle ERROR
module ahb_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hr_readyout,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [2:0] {IDLE, WAIT, ERR1, ERR2, DATA} state_t;
  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d, be_in;
  logic            write_q, write_d;
  logic [31:0]     hrdata_q, hrdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     off, wmask, rd_word;
  logic            accept, err, commit;
  // Unsigned offset compare covers both window edges in one test.
  assign off         = haddr - BASE_ADDR;
  assign accept      = hreadyin && hr_readyout && htrans inside {2'b10, 2'b11};
  assign err         = off >= 32'(4 * DEPTH_WORDS) || hsize > 3'd2 || (hsize == 3'd1 && haddr[0])
                       || (hsize == 3'd2 && haddr[1:0] != 2'b00);
  assign be_in       = hsize == 3'd0 ? 4'b0001 << haddr[1:0] : hsize == 3'd1 ? (haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign commit      = state_q == DATA && write_q;
  assign wmask       = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
  assign hr_readyout = !(state_q inside {WAIT, ERR1});
  assign hresp       = state_q inside {ERR1, ERR2} ? 2'b01 : 2'b00;
  assign hrdata      = hrdata_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    if (state_q == ERR1) state_d = ERR2;
    else if (state_q == WAIT) begin
      cnt_d   = cnt_q + 3'd1;
      state_d = int'(cnt_q) == WAIT_STATES - 1 ? DATA : WAIT;
    end else if (accept) begin
      idx_d   = off[AW+1:2];
      be_d    = be_in;
      write_d = hwrite;
      cnt_d   = '0;
      state_d = err ? ERR1 : WAIT_STATES > 0 ? WAIT : DATA;
    end else state_d = IDLE;
    // A write retiring on the same edge as a read of its word is merged into the loaded data.
    rd_word  = commit && idx_q == idx_d ? (mem_q[idx_d] & ~wmask) | (hwdata & wmask) : mem_q[idx_d];
    hrdata_d = state_d == DATA && !write_d ? rd_word : hrdata_q;
  end
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      write_q  <= write_d;
      hrdata_q <= hrdata_d;
    end
  always_ff @(posedge hclk)
    if (commit) mem_q[idx_q] <= (mem_q[idx_q] & ~wmask) | (hwdata & wmask);
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb_ahb_mem_slave: two responders (zero and two wait states) driven by a pipelined master,
// responses checked by a scoreboard fed from a byte-level memory model.
module tb_ahb_mem_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 64;
  typedef struct { logic [1:0] trans; logic wr; logic [2:0] size; logic [31:0] addr; logic [31:0] wdata; } beat_t;
  typedef struct { logic err; logic rd; int waits; logic [31:0] data; } exp_t;
  logic clk = 0;
  logic [1:0] rst_n = '0, hwrite = '0, hold = '0;
  logic [1:0][1:0] htrans = '0;
  logic [1:0][2:0] hsize = '0;
  logic [1:0][31:0] haddr = '0, hwdata = '0;
  wire [1:0] rdy_o;
  wire [1:0][1:0] hresp;
  wire [1:0][31:0] hrdata;
  wire [1:0] hreadyin = rdy_o & ~hold;
  int total = 0, bad = 0;
  logic [31:0] model [2][DEPTH];
  exp_t sb [2][$];
  beat_t bq [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_mem_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2 * g)) u_dut (
      .hclk(clk), .hresetn(rst_n[g]), .hwrite(hwrite[g]), .hreadyin(hreadyin[g]), .htrans(htrans[g]),
      .hsize(hsize[g]), .haddr(haddr[g]), .hwdata(hwdata[g]), .hr_readyout(rdy_o[g]),
      .hrdata(hrdata[g]), .hresp(hresp[g]));
  end

  task automatic chk(input string nm, input int s, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h required=%h @%0t", nm, s, act, req, $time);
    end
  endtask

  function automatic beat_t mk(input logic [1:0] t, input logic w, input logic [2:0] z, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.trans = t; b.wr = w; b.size = z; b.addr = a; b.wdata = d;
    return b;
  endfunction

  function automatic beat_t rnd();
    beat_t b;
    int p = $urandom_range(0, 9);
    b.trans = p < 7 ? 2'b10 : p == 7 ? 2'b11 : p == 8 ? 2'b01 : 2'b00;
    b.wr = 1'($urandom_range(0, 1));
    b.size = $urandom_range(0, 11) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
    b.addr = $urandom_range(0, 11) == 0 ? $urandom : BASE + $urandom_range(0, 4 * DEPTH - 1);
    if ($urandom_range(0, 3) != 0) b.addr = b.addr & ~((32'd1 << b.size) - 32'd1);
    b.wdata = $urandom;
    return b;
  endfunction

  // Reference: window/size rules evaluated arithmetically, writes applied byte by byte.
  task automatic predict(input int s, input beat_t b);
    exp_t e;
    longint a;
    int idx, n, l;
    a = longint'(b.addr);
    e.err = a < longint'(BASE) || a >= longint'(BASE) + 4 * DEPTH || b.size > 3'd2
            || (b.size == 3'd1 && b.addr % 2 != 0) || (b.size == 3'd2 && b.addr % 4 != 0);
    e.rd = !b.wr;
    e.waits = e.err ? 1 : 2 * s;
    e.data = '0;
    if (!e.err) begin
      idx = int'((a - longint'(BASE)) / 4);
      n = 1 << b.size;
      if (b.wr)
        for (int k = 0; k < n; k++) begin
          l = int'((b.addr + 32'(k)) % 4);
          model[s][idx][8*l +: 8] = b.wdata[8*l +: 8];
        end
      e.data = model[s][idx];
    end
    sb[s].push_back(e);
  endtask

  task automatic run(input int s);
    beat_t cur, dp;
    bit dpv = 0, r;
    int guard = 0;
    while (bq.size() != 0 || dpv) begin
      cur = bq.size() != 0 ? bq[0] : mk(2'b00, 1'b0, 3'd0, 32'd0, 32'd0);
      htrans[s] = cur.trans; haddr[s] = cur.addr; hwrite[s] = cur.wr; hsize[s] = cur.size;
      hwdata[s] = dpv ? dp.wdata : 32'd0;
      @(negedge clk);
      r = hreadyin[s];
      @(posedge clk);
      #1;
      if (r) begin
        if (bq.size() != 0) void'(bq.pop_front());
        dpv = cur.trans[1];
        dp = cur;
        if (dpv) predict(s, cur);
      end
      if (++guard > 5000) begin
        total++; bad++;
        $display("FAIL timeout dut%0d actual=stalled required=progress", s);
        bq.delete();
        break;
      end
    end
    htrans[s] = 2'b00; hwdata[s] = 32'd0;
  endtask

  initial begin
    exp_t e;
    int lows [2];
    bit in_dp [2];
    lows = '{0, 0};
    in_dp = '{0, 0};
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (!rst_n[s]) begin
          in_dp[s] = 0; lows[s] = 0;
        end else begin
          if (!in_dp[s]) chk("idle_okay", s, {29'd0, rdy_o[s], hresp[s]}, 32'b100);
          else if (sb[s].size() == 0) begin
            total++; bad++;
            $display("FAIL dphase_unexpected dut%0d actual=data_phase required=none", s);
          end else if (!rdy_o[s]) begin
            lows[s]++;
            chk("wait_resp", s, 32'(hresp[s]), sb[s][0].err ? 32'd1 : 32'd0);
          end else begin
            e = sb[s].pop_front();
            chk("wait_count", s, lows[s], e.waits);
            chk("resp", s, 32'(hresp[s]), e.err ? 32'd1 : 32'd0);
            if (e.rd && !e.err) chk("rdata", s, hrdata[s], e.data);
            lows[s] = 0;
          end
          if (hreadyin[s]) in_dp[s] = htrans[s][1];
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 2'b11;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", s, 32'(rdy_o[s]), 32'd1);
      chk("rst_resp", s, 32'(hresp[s]), 32'd0);
      chk("rst_rdata", s, hrdata[s], 32'd0);
    end
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < DEPTH; i++) bq.push_back(mk(2'b10, 1'b1, 3'd2, BASE + 32'(4 * i), $urandom));
      run(s);
    end
    bq.push_back(mk(2'b10, 1'b1, 3'd2, BASE, 32'h0000_0024));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE, 32'd0));
    bq.push_back(mk(2'b10, 1'b1, 3'd0, BASE, 32'h1111_1111));
    bq.push_back(mk(2'b11, 1'b1, 3'd0, BASE + 1, 32'h2222_2222));
    bq.push_back(mk(2'b11, 1'b1, 3'd0, BASE + 2, 32'h3333_3333));
    bq.push_back(mk(2'b11, 1'b1, 3'd0, BASE + 3, 32'h4444_4444));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE, 32'd0));
    run(0);
    bq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h9000_0000, 32'd0));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 4, 32'd0));
    bq.push_back(mk(2'b10, 1'b1, 3'd2, BASE + 2, 32'hFFFF_FFFF));
    bq.push_back(mk(2'b10, 1'b1, 3'd1, BASE + 1, 32'hFFFF_FFFF));
    bq.push_back(mk(2'b10, 1'b1, 3'd3, BASE + 4, 32'hFFFF_FFFF));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE, 32'd0));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 4, 32'd0));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 4 * DEPTH, 32'd0));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 4 * DEPTH - 4, 32'd0));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE - 4, 32'd0));
    bq.push_back(mk(2'b10, 1'b1, 3'd2, BASE + 8, 32'hDEAD_BEEF));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 8, 32'd0));
    run(0);
    hold[0] = 1'b1;
    htrans[0] = 2'b10; haddr[0] = BASE + 16; hwrite[0] = 1'b1; hsize[0] = 3'd2; hwdata[0] = 32'hA5A5_A5A5;
    repeat (3) @(posedge clk);
    #1 htrans[0] = 2'b00;
    hold[0] = 1'b0;
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 16, 32'd0));
    run(0);
    repeat (300) bq.push_back(rnd());
    run(0);
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 4, 32'd0));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, 32'h9000_0000, 32'd0));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 4, 32'd0));
    bq.push_back(mk(2'b10, 1'b1, 3'd2, BASE + 8, 32'h1234_5678));
    bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 8, 32'd0));
    run(1);
    repeat (150) bq.push_back(rnd());
    run(1);
    htrans[1] = 2'b10; haddr[1] = BASE + 12; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk);
    #1 htrans[1] = 2'b00;
    hwdata[1] = 32'h0BAD_F00D;
    chk("in_wait", 1, 32'(rdy_o[1]), 32'd0);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("rst_mid_ready", 1, 32'(rdy_o[1]), 32'd1);
    chk("rst_mid_resp", 1, 32'(hresp[1]), 32'd0);
    chk("rst_mid_rdata", 1, hrdata[1], 32'd0);
    @(negedge clk);
    #1 rst_n[1] = 1'b1;
    @(posedge clk);
    #1 bq.push_back(mk(2'b10, 1'b0, 3'd2, BASE + 12, 32'd0));
    run(1);
    repeat (4) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) chk("sb_drain", s, sb[s].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
